// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM state type and counter-width helper for the parity frame checker.
package parity_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, DONE} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/parity_acc.sv
// parity_acc: 1-bit XOR accumulator with synchronous load of an initial value and an enable.
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic init_i,
  input  logic en_i,
  input  logic d_i,
  output logic acc_o
);
  logic acc_q, acc_d;
  assign acc_d = load_i ? init_i : en_i ? acc_q ^ d_i : acc_q;
  always_ff @(posedge clk)
    if (!rst_n) acc_q <= 1'b0;
    else        acc_q <= acc_d;
  assign acc_o = acc_q;
endmodule

// File: rtl/parity_frame_checker.sv
// parity_frame_checker: receives start + DATA_BITS serial bits + parity bit, reassembles the word and checks parity.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int   DATA_BITS = 8,
  parameter logic ODD       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 parity_ok,
  output logic                 calc_parity,
  output logic [DATA_BITS-1:0] data_out
);
  localparam int CW = cnt_w(DATA_BITS);
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sr_q, sr_d, data_q, data_d;
  logic                 pok_q, pok_d, cpar_q, cpar_d;
  logic                 acc, take_start, shift_en, par_en, last;
  assign take_start = (state_q == IDLE) && start;
  assign shift_en   = (state_q == DATA) && bit_valid;
  assign par_en     = (state_q == PARITY) && bit_valid;
  assign last       = cnt_q == CW'(DATA_BITS - 1);
  parity_acc u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (take_start),
    .init_i (ODD),
    .en_i   (shift_en),
    .d_i    (bit_in),
    .acc_o  (acc)
  );
  // Shift register is cleared on start, so OR-ing each bit into place at cnt is enough.
  always_comb begin
    state_d = take_start ? DATA : (shift_en && last) ? PARITY : par_en ? DONE :
              (state_q == DONE) ? IDLE : state_q;
    cnt_d   = take_start ? '0 : shift_en ? cnt_q + CW'(1) : cnt_q;
    sr_d    = take_start ? '0 : shift_en ? (sr_q | (DATA_BITS'(bit_in) << cnt_q)) : sr_q;
    data_d  = par_en ? sr_q : data_q;
    cpar_d  = par_en ? acc : cpar_q;
    pok_d   = par_en ? (bit_in == acc) : pok_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      cpar_q  <= 1'b0;
      pok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      cpar_q  <= cpar_d;
      pok_q   <= pok_d;
    end
  assign busy        = (state_q == DATA) || (state_q == PARITY);
  assign frame_done  = state_q == DONE;
  assign parity_ok   = pok_q;
  assign calc_parity = cpar_q;
  assign data_out    = data_q;
endmodule
